mem_sp_hs: RTL and testbench

Parametrised single-port synchronous memory with a valid/ready request handshake, byte-write strobes, a registered one-cycle read path and a self-clearing initialisation sequence after reset. It generalises the team's plain width × depth memory:
- arbitrary WIDTH/DEPTH;
- partial writes;
- out-of-range address detection;
- guaranteed known contents after reset.

It sits between a bus-side requester, such as a DMA or register-file front end, and on-chip storage.

---
 rtl/mem_sp_hs.sv | 112 +++++++++++
 tb/tb_mem_sp_hs.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_sp_hs.sv
// Single-port synchronous memory with valid/ready requests, byte strobes,
// registered read data and a zero-fill sequence after every reset.
module mem_sp_hs #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1600,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    localparam int STRB_W    = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [STRB_W-1:0]     wstrb,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rd_valid,
    output logic                  err,
    output logic                  init_done
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [WIDTH-1:0]      r_rdata;
    logic                  r_rd_valid;
    logic                  r_err;
    logic [31:0]           w_addr_ext;
    logic                  w_oor;
    logic                  w_acc;

    // Widen before comparing so a power-of-two DEPTH cannot wrap the check.
    assign w_addr_ext = 32'(addr);
    assign w_oor      = (w_addr_ext >= 32'(DEPTH));
    assign w_acc      = valid && (r_state == S_RUN);

    assign ready     = (r_state == S_RUN);
    assign init_done = (r_state == S_RUN);
    assign rdata     = r_rdata;
    assign rd_valid  = r_rd_valid;
    assign err       = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // Storage carries no reset; the INIT sweep provides known contents.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_acc && wr_rd && !w_oor) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            if (w_acc) begin
                r_err <= w_oor;
                if (!wr_rd) begin
                    r_rd_valid <= 1'b1;
                    r_rdata    <= w_oor ? '0 : r_mem[addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_sp_hs.sv
// Directed bench for mem_sp_hs: init sweep, strobed writes, range errors,
// back-to-back traffic and reset in the middle of a burst.
module tb_mem_sp_hs;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic        wr_rd;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        err;
    logic        init_done;

    int tests;
    int fails;
    int n;

    mem_sp_hs #(
        .WIDTH(32),
        .DEPTH(1600)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid(valid),
        .ready(ready),
        .wr_rd(wr_rd),
        .addr(addr),
        .wdata(wdata),
        .wstrb(wstrb),
        .rdata(rdata),
        .rd_valid(rd_valid),
        .err(err),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [10:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        valid = v;
        wr_rd = w;
        addr  = a;
        wdata = d;
        wstrb = s;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        n = 0;
        while (!ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(n), 32'd1600);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        valid = 1'b1;
        wr_rd = 1'b0;
        addr  = 11'd5;
        wdata = '0;
        wstrb = '0;
        rst   = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        wait_ready("init_edges");
        chk("init_done_rise", 32'(init_done), 32'd1);
        chk("init_no_rd_yet", 32'(rd_valid), 32'd0);
        step(1'b1, 1'b0, 11'd5, 32'h0, 4'h0);
        chk("init_rd_valid", 32'(rd_valid), 32'd1);
        chk("init_rd_data", rdata, 32'h0);

        step(1'b1, 1'b1, 11'd5, 32'hDEADBEEF, 4'hF);
        chk("wr_no_rd_valid", 32'(rd_valid), 32'd0);
        chk("wr_no_err", 32'(err), 32'd0);
        step(1'b1, 1'b0, 11'd5, 32'h0, 4'h0);
        chk("full_rd_data", rdata, 32'hDEADBEEF);
        chk("full_rd_valid", 32'(rd_valid), 32'd1);
        step(1'b0, 1'b0, 11'd5, 32'h0, 4'h0);
        chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
        chk("rdata_hold", rdata, 32'hDEADBEEF);

        step(1'b1, 1'b1, 11'd5, 32'h00005500, 4'b0010);
        step(1'b1, 1'b0, 11'd5, 32'h0, 4'h0);
        chk("strb_rd_data", rdata, 32'hDEAD55EF);
        step(1'b1, 1'b1, 11'd5, 32'hFFFFFFFF, 4'h0);
        step(1'b1, 1'b0, 11'd5, 32'h0, 4'h0);
        chk("strb0_rd_data", rdata, 32'hDEAD55EF);

        step(1'b1, 1'b1, 11'd1600, 32'h12345678, 4'hF);
        chk("oor_wr_err", 32'(err), 32'd1);
        chk("oor_wr_rd_valid", 32'(rd_valid), 32'd0);
        step(1'b1, 1'b0, 11'd0, 32'h0, 4'h0);
        chk("alias_rd_data", rdata, 32'h0);
        chk("alias_err", 32'(err), 32'd0);
        step(1'b1, 1'b0, 11'd2047, 32'h0, 4'h0);
        chk("oor_rd_data", rdata, 32'h0);
        chk("oor_rd_valid", 32'(rd_valid), 32'd1);
        chk("oor_rd_err", 32'(err), 32'd1);
        step(1'b0, 1'b0, 11'd0, 32'h0, 4'h0);
        chk("err_pulse", 32'(err), 32'd0);

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 11'(i), 32'hC0DE0000 | 32'(i * 17), 4'hF);
            chk("b2b_wr_ready", 32'(ready), 32'd1);
            chk("b2b_wr_rd_valid", 32'(rd_valid), 32'd0);
            step(1'b1, 1'b0, 11'(i), 32'h0, 4'h0);
            chk("b2b_rd_valid", 32'(rd_valid), 32'd1);
            chk("b2b_rd_data", rdata, 32'hC0DE0000 | 32'(i * 17));
        end
        step(1'b1, 1'b0, 11'd5, 32'h0, 4'h0);
        chk("b2b_keep_5", rdata, 32'hC0DE0055);
        step(1'b1, 1'b0, 11'd8, 32'h0, 4'h0);
        chk("b2b_untouched_8", rdata, 32'h0);

        step(1'b1, 1'b1, 11'd3, 32'hA5A5A5A5, 4'hF);
        step(1'b1, 1'b0, 11'd3, 32'h0, 4'h0);
        chk("pre_rst_rd_data", rdata, 32'hA5A5A5A5);
        chk("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_done", 32'(init_done), 32'd0);
        #1 rst = 1'b0;
        wait_ready("reinit_edges");
        step(1'b1, 1'b0, 11'd3, 32'h0, 4'h0);
        chk("reinit_rd_valid", 32'(rd_valid), 32'd1);
        chk("reinit_rd_data", rdata, 32'h0);
        step(1'b1, 1'b0, 11'd5, 32'h0, 4'h0);
        chk("reinit_rd_5", rdata, 32'h0);
        valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
